// File: rtl/miller_rx_pkg.sv
// Shared definitions for the Miller receive path.
// Holds the sequencer state encodings, the completion status codes, the
// Miller M select codes and the CRC-16/CCITT constants. It also holds a
// one-bit CRC step function, so that every CRC user in the baseband
// computes the same thing.
package miller_rx_pkg;

   // Receive sequencer states
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ARM        = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_RECV       = 3'd3,
      ST_CHECK      = 3'd4,
      ST_FIN        = 3'd5
   } rxState_e;

   // Completion status reported to the protocol FSM alongside rx_done
   typedef enum logic [2:0] {
      RX_OK       = 3'd0,
      RX_NO_REPLY = 3'd1,
      RX_GAP_TO   = 3'd2,
      RX_SHORT    = 3'd3,
      RX_CRC_ERR  = 3'd4,
      RX_ABORT    = 3'd5
   } rxStatus_e;

   // Miller subcarrier M select codes driven to the decoder
   localparam logic [1:0] M_CODE_M2 = 2'b01;
   localparam logic [1:0] M_CODE_M4 = 2'b10;
   localparam logic [1:0] M_CODE_M8 = 2'b11;

   // CRC-16/CCITT, MSB-first. A frame that carries its own ones-complemented
   // CRC leaves CRC16_RESIDUE in the register once every bit has been shifted in.
   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

   // The reserved code 00 is mapped to M8, the most robust setting
   function automatic logic [1:0] normalizeM(input logic [1:0] m);
      logic [1:0] result;
      case (m)
         M_CODE_M2: result = M_CODE_M2;
         M_CODE_M4: result = M_CODE_M4;
         default:   result = M_CODE_M8;
      endcase
      return result;
   endfunction

   // Advance the CRC register by one serial bit
   function automatic logic [15:0] crc16Step(input logic [15:0] crc, input logic din);
      logic feedback;
      feedback = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16/CCITT register, shared by the receive and transmit paths.
// Ports:
//   base_clk  block clock, rising edge
//   rst       synchronous active-high reset, loads the preset
//   clr       synchronous clear back to the preset (start of a new frame)
//   en        shift din into the register this cycle
//   din       serial data bit, MSB-first
//   crc       current register contents
module crc16_serial (
   input  logic        base_clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);
   import miller_rx_pkg::*;

   // The register holds the preset between frames. Clearing has priority
   // over shifting, so a frame always starts from a clean preset.
   always_ff @(posedge base_clk) begin
      if (rst || clr) begin
         crc <= CRC16_PRESET;
      end else if (en) begin
         crc <= crc16Step(crc, din);
      end
   end

endmodule

// File: rtl/miller_rx_ctrl.sv
// Receive-path sequencer between the protocol FSM and the Miller decoder.
// When a request arrives it takes the decoder out of reset and enables it,
// then waits for the reply start within the T1 window. It shifts decoded
// bits into a frame register, optionally checks CRC-16, and reports one
// rx_done pulse with a status code.
// Ports:
//   base_clk, rst                  clock (rising edge) and sync active-high reset
//   rx_req, rx_len, rx_m, crc_en   request plus frame parameters (IDLE only)
//   t1_max, gap_max                reply-start and inter-bit timeout limits
//   rx_abort                       aborts an active receive
//   dec_rst_n, dec_en, dec_m       decoder reset (active-low), enable, M value
//   miller_start/clk/data/done     asynchronous decoder outputs
//   rx_busy, rx_done, rx_status    sequencer status towards the protocol FSM
//   rx_frame, rx_bit_cnt           captured bits (last bit at index 0) and count
module miller_rx_ctrl #(
   parameter int MAX_BITS = 128,
   parameter int LEN_W    = 8,
   parameter int TO_W     = 16
) (
   input  logic                base_clk,
   input  logic                rst,
   input  logic                rx_req,
   input  logic [LEN_W-1:0]    rx_len,
   input  logic [1:0]          rx_m,
   input  logic                crc_en,
   input  logic [TO_W-1:0]     t1_max,
   input  logic [TO_W-1:0]     gap_max,
   input  logic                rx_abort,
   output logic                dec_rst_n,
   output logic                dec_en,
   output logic [1:0]          dec_m,
   input  logic                miller_start,
   input  logic                miller_clk,
   input  logic                miller_data,
   input  logic                miller_done,
   output logic                rx_busy,
   output logic                rx_done,
   output logic [2:0]          rx_status,
   output logic [MAX_BITS-1:0] rx_frame,
   output logic [LEN_W-1:0]    rx_bit_cnt
);
   import miller_rx_pkg::*;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

   // Synchroniser chains: [0] first flop, [1] second flop (safe to use),
   // [2] previous value of [1] for rising-edge detection
   logic [2:0]        startSync;
   logic [2:0]        clkSync;
   logic [2:0]        doneSync;
   logic [1:0]        dataSync;

   logic              startEdge;
   logic              clkEdge;
   logic              doneEdge;
   logic              bitVal;

   rxState_e          state;
   logic [LEN_W-1:0]  lenLatched;
   logic              crcEnLatched;
   logic [TO_W-1:0]   t1Latched;
   logic [TO_W-1:0]   gapLatched;
   logic [TO_W-1:0]   t1Cnt;
   logic [TO_W-1:0]   gapCnt;

   logic [LEN_W-1:0]  lenClamped;
   logic [LEN_W-1:0]  nextBitCnt;
   logic              crcClr;
   logic              crcShift;
   logic [15:0]       crcValue;

   // The decoder outputs come from another clock domain, so each one passes
   // through two flops before use. Edges are found on the synchronised
   // copies, and the data bit uses the same two-flop delay so that it stays
   // aligned with its strobe.
   always_ff @(posedge base_clk) begin
      if (rst) begin
         startSync <= '0;
         clkSync   <= '0;
         doneSync  <= '0;
         dataSync  <= '0;
      end else begin
         startSync <= {startSync[1:0], miller_start};
         clkSync   <= {clkSync[1:0],   miller_clk};
         doneSync  <= {doneSync[1:0],  miller_done};
         dataSync  <= {dataSync[0],    miller_data};
      end
   end

   assign startEdge = startSync[1] & ~startSync[2];
   assign clkEdge   = clkSync[1]   & ~clkSync[2];
   assign doneEdge  = doneSync[1]  & ~doneSync[2];
   assign bitVal    = dataSync[1];

   // Bring a requested length into the legal range: a zero-length request
   // still captures one bit, and anything longer than the frame register
   // is cut to the register size.
   always_comb begin
      lenClamped = rx_len;
      if (rx_len == '0) begin
         lenClamped = LEN_W'(1);
      end else if (rx_len > MAX_LEN) begin
         lenClamped = MAX_LEN;
      end
   end

   assign nextBitCnt = rx_bit_cnt + 1'b1;

   // The CRC restarts when a request is accepted. It advances on exactly the
   // cycles that shift a bit into the frame; an abort suppresses both.
   assign crcClr   = (state == ST_IDLE) && rx_req;
   assign crcShift = (state == ST_RECV) && clkEdge && !rx_abort;

   crc16_serial u_crc (
      .base_clk (base_clk),
      .rst      (rst),
      .clr      (crcClr),
      .en       (crcShift),
      .din      (bitVal),
      .crc      (crcValue)
   );

   // Main sequencer, with every output registered. The decoder controls
   // change on the edge that enters ARM, so the decoder is already out of
   // reset and enabled while ARM lasts. Every path into FIN raises rx_done
   // and shuts the decoder down on that same edge. An abort overrides
   // anything else that happens in the same cycle, except in IDLE and FIN,
   // where nothing is left to abort.
   always_ff @(posedge base_clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         dec_rst_n    <= 1'b0;
         dec_en       <= 1'b0;
         dec_m        <= M_CODE_M8;
         rx_busy      <= 1'b0;
         rx_done      <= 1'b0;
         rx_status    <= RX_OK;
         rx_frame     <= '0;
         rx_bit_cnt   <= '0;
         lenLatched   <= LEN_W'(1);
         crcEnLatched <= 1'b0;
         t1Latched    <= '0;
         gapLatched   <= '0;
         t1Cnt        <= '0;
         gapCnt       <= '0;
      end else begin
         rx_done <= 1'b0;
         if (rx_abort && (state != ST_IDLE) && (state != ST_FIN)) begin
            state     <= ST_FIN;
            rx_done   <= 1'b1;
            dec_en    <= 1'b0;
            dec_rst_n <= 1'b0;
            rx_status <= RX_ABORT;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rx_req) begin
                     lenLatched   <= lenClamped;
                     crcEnLatched <= crc_en;
                     t1Latched    <= t1_max;
                     gapLatched   <= gap_max;
                     rx_frame     <= '0;
                     rx_bit_cnt   <= '0;
                     rx_status    <= RX_OK;
                     rx_busy      <= 1'b1;
                     dec_rst_n    <= 1'b1;
                     dec_en       <= 1'b1;
                     dec_m        <= normalizeM(rx_m);
                     state        <= ST_ARM;
                  end else begin
                     dec_rst_n <= 1'b0;
                     dec_en    <= 1'b0;
                  end
               end

               ST_ARM: begin
                  t1Cnt <= '0;
                  state <= ST_WAIT_START;
               end

               ST_WAIT_START: begin
                  if (startEdge) begin
                     gapCnt <= '0;
                     state  <= ST_RECV;
                  end else if (t1Cnt == t1Latched) begin
                     state     <= ST_FIN;
                     rx_done   <= 1'b1;
                     dec_en    <= 1'b0;
                     dec_rst_n <= 1'b0;
                     rx_status <= RX_NO_REPLY;
                  end else if (t1Cnt != '1) begin
                     t1Cnt <= t1Cnt + 1'b1;
                  end
               end

               ST_RECV: begin
                  if (clkEdge) begin
                     rx_frame   <= {rx_frame[MAX_BITS-2:0], bitVal};
                     rx_bit_cnt <= nextBitCnt;
                     gapCnt     <= '0;
                     if (nextBitCnt == lenLatched) begin
                        state <= ST_CHECK;
                     end else if (doneEdge) begin
                        state     <= ST_FIN;
                        rx_done   <= 1'b1;
                        dec_en    <= 1'b0;
                        dec_rst_n <= 1'b0;
                        rx_status <= RX_SHORT;
                     end
                  end else if (doneEdge) begin
                     state     <= ST_FIN;
                     rx_done   <= 1'b1;
                     dec_en    <= 1'b0;
                     dec_rst_n <= 1'b0;
                     rx_status <= RX_SHORT;
                  end else if (gapCnt == gapLatched) begin
                     state     <= ST_FIN;
                     rx_done   <= 1'b1;
                     dec_en    <= 1'b0;
                     dec_rst_n <= 1'b0;
                     rx_status <= RX_GAP_TO;
                  end else if (gapCnt != '1) begin
                     gapCnt <= gapCnt + 1'b1;
                  end
               end

               ST_CHECK: begin
                  state     <= ST_FIN;
                  rx_done   <= 1'b1;
                  dec_en    <= 1'b0;
                  dec_rst_n <= 1'b0;
                  if (crcEnLatched && (crcValue != CRC16_RESIDUE)) begin
                     rx_status <= RX_CRC_ERR;
                  end else begin
                     rx_status <= RX_OK;
                  end
               end

               ST_FIN: begin
                  rx_busy <= 1'b0;
                  state   <= ST_IDLE;
               end

               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_miller_rx_ctrl.sv
// Directed testbench for miller_rx_ctrl. It drives the decoder pulses by
// hand and compares the outputs against values worked out in advance.
module tb_miller_rx_ctrl;

   logic         base_clk = 1'b0;
   logic         rst = 1'b1;
   logic         rx_req = 1'b0;
   logic [7:0]   rx_len = 8'd0;
   logic [1:0]   rx_m = 2'b01;
   logic         crc_en = 1'b0;
   logic [15:0]  t1_max = 16'd0;
   logic [15:0]  gap_max = 16'd0;
   logic         rx_abort = 1'b0;
   logic         dec_rst_n;
   logic         dec_en;
   logic [1:0]   dec_m;
   logic         miller_start = 1'b0;
   logic         miller_clk = 1'b0;
   logic         miller_data = 1'b0;
   logic         miller_done = 1'b0;
   logic         rx_busy;
   logic         rx_done;
   logic [2:0]   rx_status;
   logic [127:0] rx_frame;
   logic [7:0]   rx_bit_cnt;

   int           passCount = 0;
   int           failCount = 0;
   int           checkCount = 0;
   int           cycleNo = 0;
   int           doneCount = 0;
   int           doneCycle = 0;
   logic [2:0]   doneStatus = 3'd0;

   miller_rx_ctrl dut (
      .base_clk     (base_clk),
      .rst          (rst),
      .rx_req       (rx_req),
      .rx_len       (rx_len),
      .rx_m         (rx_m),
      .crc_en       (crc_en),
      .t1_max       (t1_max),
      .gap_max      (gap_max),
      .rx_abort     (rx_abort),
      .dec_rst_n    (dec_rst_n),
      .dec_en       (dec_en),
      .dec_m        (dec_m),
      .miller_start (miller_start),
      .miller_clk   (miller_clk),
      .miller_data  (miller_data),
      .miller_done  (miller_done),
      .rx_busy      (rx_busy),
      .rx_done      (rx_done),
      .rx_status    (rx_status),
      .rx_frame     (rx_frame),
      .rx_bit_cnt   (rx_bit_cnt)
   );

   // 100 MHz block clock
   always #5 base_clk = ~base_clk;

   // Free-running edge counter, used to time the no-reply timeout
   always @(posedge base_clk) cycleNo <= cycleNo + 1;

   // Record every completion pulse so that pulses falling inside a stimulus
   // task are not missed
   always @(negedge base_clk) begin
      if (rx_done) begin
         doneCount  <= doneCount + 1;
         doneCycle  <= cycleNo;
         doneStatus <= rx_status;
      end
   end

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge base_clk);
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] len, input logic [1:0] m, input logic crcOn,
                                input logic [15:0] t1, input logic [15:0] gap);
      tick(3);
      rx_len  = len;
      rx_m    = m;
      crc_en  = crcOn;
      t1_max  = t1;
      gap_max = gap;
      rx_req  = 1'b1;
      tick(1);
      rx_req  = 1'b0;
   endtask

   task automatic sendStart();
      miller_start = 1'b1;
      tick(2);
      miller_start = 1'b0;
      tick(2);
   endtask

   task automatic sendBit(input logic b, input int spacing);
      miller_data = b;
      miller_clk  = 1'b1;
      tick(2);
      miller_clk  = 1'b0;
      tick(spacing - 2);
   endtask

   task automatic waitDone(input string tag, input int budget, input int base);
      int i;
      i = 0;
      while (doneCount == base && i < budget) begin
         tick(1);
         i++;
      end
      checkOutput(tag, 128'(doneCount != base), 128'(1));
   endtask

   initial begin
      int base;
      int c0;
      logic [15:0]  okWord;
      logic [31:0]  crcWord;
      logic [9:0]   shortWord;
      logic [127:0] expFrame;
      logic [7:0]   byteWord;
      logic         b;

      // Reset state
      tick(3);
      checkOutput("rst_dec_rst_n", 128'(dec_rst_n), 128'(0));
      checkOutput("rst_dec_en", 128'(dec_en), 128'(0));
      checkOutput("rst_dec_m", 128'(dec_m), 128'(2'b11));
      checkOutput("rst_busy", 128'(rx_busy), 128'(0));
      checkOutput("rst_done", 128'(rx_done), 128'(0));
      checkOutput("rst_status", 128'(rx_status), 128'(0));
      checkOutput("rst_frame", rx_frame, 128'(0));
      checkOutput("rst_bitcnt", 128'(rx_bit_cnt), 128'(0));
      rst = 1'b0;

      // OK frame, M2, bits 40 cycles apart
      base = doneCount;
      applyStimulus(8'd16, 2'b01, 1'b0, 16'd1000, 16'd200);
      checkOutput("ok_busy_arm", 128'(rx_busy), 128'(1));
      checkOutput("ok_dec_rst_n_arm", 128'(dec_rst_n), 128'(1));
      checkOutput("ok_dec_en_arm", 128'(dec_en), 128'(1));
      tick(20);
      sendStart();
      checkOutput("ok_dec_m_busy", 128'(dec_m), 128'(2'b01));
      okWord = 16'hA5C3;
      for (int i = 15; i >= 0; i--) sendBit(okWord[i], 40);
      waitDone("ok_done", 50, base);
      checkOutput("ok_status", 128'(doneStatus), 128'(0));
      checkOutput("ok_bitcnt", 128'(rx_bit_cnt), 128'(16));
      checkOutput("ok_frame", rx_frame, 128'(16'hA5C3));
      tick(2);
      checkOutput("ok_busy_after", 128'(rx_busy), 128'(0));

      // No reply within t1_max = 100
      base = doneCount;
      applyStimulus(8'd8, 2'b10, 1'b0, 16'd100, 16'd200);
      c0 = cycleNo;
      checkOutput("noreply_dec_m", 128'(dec_m), 128'(2'b10));
      waitDone("noreply_done", 150, base);
      checkOutput("noreply_latency", 128'(doneCycle - c0 - 1), 128'(101));
      checkOutput("noreply_status", 128'(doneStatus), 128'(1));
      checkOutput("noreply_bitcnt", 128'(rx_bit_cnt), 128'(0));
      tick(2);
      checkOutput("noreply_dec_en_after", 128'(dec_en), 128'(0));

      // CRC good: 0x0000 followed by the complement of its CRC (~0x1D0F)
      base = doneCount;
      applyStimulus(8'd32, 2'b11, 1'b1, 16'd1000, 16'd200);
      tick(5);
      sendStart();
      crcWord = 32'h0000_E2F0;
      for (int i = 31; i >= 0; i--) sendBit(crcWord[i], 8);
      waitDone("crcgood_done", 50, base);
      checkOutput("crcgood_status", 128'(doneStatus), 128'(0));
      checkOutput("crcgood_frame", rx_frame, 128'(crcWord));

      // CRC bad: last bit flipped
      base = doneCount;
      applyStimulus(8'd32, 2'b11, 1'b1, 16'd1000, 16'd200);
      tick(5);
      sendStart();
      crcWord = 32'h0000_E2F1;
      for (int i = 31; i >= 0; i--) sendBit(crcWord[i], 8);
      waitDone("crcbad_done", 50, base);
      checkOutput("crcbad_status", 128'(doneStatus), 128'(4));

      // Short frame: done after 10 of 24 bits
      base = doneCount;
      applyStimulus(8'd24, 2'b01, 1'b0, 16'd1000, 16'd200);
      tick(5);
      sendStart();
      shortWord = 10'b1011001110;
      for (int i = 9; i >= 0; i--) sendBit(shortWord[i], 8);
      miller_done = 1'b1;
      tick(2);
      miller_done = 1'b0;
      waitDone("short_done", 50, base);
      checkOutput("short_status", 128'(doneStatus), 128'(3));
      checkOutput("short_bitcnt", 128'(rx_bit_cnt), 128'(10));
      checkOutput("short_frame", rx_frame, 128'(10'b1011001110));

      // Gap timeout: stream stops after 5 bits
      base = doneCount;
      applyStimulus(8'd16, 2'b10, 1'b0, 16'd1000, 16'd200);
      tick(5);
      sendStart();
      for (int i = 0; i < 5; i++) sendBit(i[0] ? 1'b0 : 1'b1, 8);
      waitDone("gap_done", 300, base);
      checkOutput("gap_status", 128'(doneStatus), 128'(2));
      checkOutput("gap_bitcnt", 128'(rx_bit_cnt), 128'(5));
      checkOutput("gap_frame", rx_frame, 128'(5'b10101));

      // Abort at bit 7: completion on the very next cycle
      applyStimulus(8'd16, 2'b01, 1'b0, 16'd1000, 16'd200);
      tick(5);
      sendStart();
      for (int i = 0; i < 7; i++) sendBit(1'b1, 8);
      rx_abort = 1'b1;
      tick(1);
      rx_abort = 1'b0;
      checkOutput("abort_done_next", 128'(rx_done), 128'(1));
      checkOutput("abort_status", 128'(rx_status), 128'(5));
      checkOutput("abort_bitcnt", 128'(rx_bit_cnt), 128'(7));

      // Reset at bit 7 of a new frame: back to idle, no completion pulse
      applyStimulus(8'd16, 2'b01, 1'b0, 16'd1000, 16'd200);
      tick(5);
      sendStart();
      for (int i = 0; i < 7; i++) sendBit(1'b1, 8);
      base = doneCount;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checkOutput("rstmid_busy", 128'(rx_busy), 128'(0));
      checkOutput("rstmid_frame", rx_frame, 128'(0));
      checkOutput("rstmid_dec_rst_n", 128'(dec_rst_n), 128'(0));
      tick(30);
      checkOutput("rstmid_no_done", 128'(doneCount - base), 128'(0));

      // rx_len = 0 behaves as one bit
      base = doneCount;
      applyStimulus(8'd0, 2'b01, 1'b0, 16'd1000, 16'd200);
      tick(5);
      sendStart();
      sendBit(1'b1, 8);
      waitDone("len0_done", 50, base);
      checkOutput("len0_status", 128'(doneStatus), 128'(0));
      checkOutput("len0_bitcnt", 128'(rx_bit_cnt), 128'(1));
      checkOutput("len0_frame", rx_frame, 128'(1));

      // rx_len = 200 clamps to 128 bits
      base = doneCount;
      applyStimulus(8'd200, 2'b01, 1'b0, 16'd1000, 16'd200);
      tick(5);
      sendStart();
      expFrame = '0;
      for (int i = 0; i < 128; i++) begin
         b = ((i % 3) == 0) ^ ((i % 7) == 1);
         expFrame = {expFrame[126:0], b};
         sendBit(b, 8);
      end
      waitDone("clamp_done", 50, base);
      checkOutput("clamp_status", 128'(doneStatus), 128'(0));
      checkOutput("clamp_bitcnt", 128'(rx_bit_cnt), 128'(128));
      checkOutput("clamp_frame", rx_frame, expFrame);

      // Second request while busy is ignored: length and M stay from the first
      base = doneCount;
      applyStimulus(8'd8, 2'b01, 1'b0, 16'd1000, 16'd200);
      applyStimulus(8'd4, 2'b10, 1'b0, 16'd1000, 16'd200);
      checkOutput("busyreq_dec_m", 128'(dec_m), 128'(2'b01));
      sendStart();
      byteWord = 8'hC6;
      for (int i = 7; i >= 0; i--) sendBit(byteWord[i], 8);
      waitDone("busyreq_done", 50, base);
      checkOutput("busyreq_status", 128'(doneStatus), 128'(0));
      checkOutput("busyreq_bitcnt", 128'(rx_bit_cnt), 128'(8));
      checkOutput("busyreq_frame", rx_frame, 128'(8'hC6));

      // Final bit coincident with miller_done still completes OK
      base = doneCount;
      applyStimulus(8'd8, 2'b01, 1'b0, 16'd1000, 16'd200);
      tick(5);
      sendStart();
      byteWord = 8'h3B;
      for (int i = 7; i >= 1; i--) sendBit(byteWord[i], 8);
      miller_data = byteWord[0];
      miller_clk  = 1'b1;
      miller_done = 1'b1;
      tick(2);
      miller_clk  = 1'b0;
      miller_done = 1'b0;
      waitDone("coinc_done", 50, base);
      checkOutput("coinc_status", 128'(doneStatus), 128'(0));
      checkOutput("coinc_bitcnt", 128'(rx_bit_cnt), 128'(8));
      checkOutput("coinc_frame", rx_frame, 128'(8'h3B));

      tick(5);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
